// File: rtl/commit_trace_buffer_if.sv
// Commit-trace bus between the core-side producer, the trace buffer and the
// checker. The master side drives commits and the ready; the slave side (the
// buffer) drives the head record and its valid.
interface commit_trace_buffer_if;
    logic        in_valid;
    logic [31:0] in_inst;
    logic [31:0] in_pc;
    logic [31:0] in_next_pc;
    logic        in_mem_rvalid;
    logic [31:0] in_mem_raddr;
    logic [6:0]  in_mem_rwidth;
    logic [31:0] in_mem_rdata;
    logic        in_mem_wvalid;
    logic [31:0] in_mem_waddr;
    logic [6:0]  in_mem_wwidth;
    logic [31:0] in_mem_wdata;
    logic        in_evt_valid;
    logic [31:0] in_evt_cause;

    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_inst;
    logic [31:0] out_pc;
    logic [31:0] out_next_pc;
    logic        out_mem_rvalid;
    logic [31:0] out_mem_raddr;
    logic [6:0]  out_mem_rwidth;
    logic [31:0] out_mem_rdata;
    logic        out_mem_wvalid;
    logic [31:0] out_mem_waddr;
    logic [6:0]  out_mem_wwidth;
    logic [31:0] out_mem_wdata;
    logic        out_evt_valid;
    logic [31:0] out_evt_cause;

    modport master (
        output in_valid, in_inst, in_pc, in_next_pc,
               in_mem_rvalid, in_mem_raddr, in_mem_rwidth, in_mem_rdata,
               in_mem_wvalid, in_mem_waddr, in_mem_wwidth, in_mem_wdata,
               in_evt_valid, in_evt_cause, out_ready,
        input  out_valid, out_inst, out_pc, out_next_pc,
               out_mem_rvalid, out_mem_raddr, out_mem_rwidth, out_mem_rdata,
               out_mem_wvalid, out_mem_waddr, out_mem_wwidth, out_mem_wdata,
               out_evt_valid, out_evt_cause
    );

    modport slave (
        input  in_valid, in_inst, in_pc, in_next_pc,
               in_mem_rvalid, in_mem_raddr, in_mem_rwidth, in_mem_rdata,
               in_mem_wvalid, in_mem_waddr, in_mem_wwidth, in_mem_wdata,
               in_evt_valid, in_evt_cause, out_ready,
        output out_valid, out_inst, out_pc, out_next_pc,
               out_mem_rvalid, out_mem_raddr, out_mem_rwidth, out_mem_rdata,
               out_mem_wvalid, out_mem_waddr, out_mem_wwidth, out_mem_wdata,
               out_evt_valid, out_evt_cause
    );
endinterface

// File: rtl/commit_trace_buffer.sv
// Commit trace buffer: captures one commit record per cycle from a core that
// cannot stall, and replays them to the checker over valid/ready. Records that
// arrive while full are dropped, flagged sticky and counted (saturating).
// Optional feature macro COMMIT_TRACE_SEQCHK_EN adds a per-record sequence
// number (out_seq) and a sticky PC-discontinuity flag (pc_break).
module commit_trace_buffer #(
    parameter int DEPTH = 4,
    parameter int CNT_W = 8
) (
    input  logic                     clock,
    input  logic                     reset,
    commit_trace_buffer_if.slave     bus,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     overflow,
    output logic [CNT_W-1:0]         drop_cnt
`ifdef COMMIT_TRACE_SEQCHK_EN
    ,
    output logic [31:0]              out_seq,
    output logic                     pc_break
`endif
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;
    localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(DEPTH);

    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] pc;
        logic [31:0] next_pc;
        logic        mem_rvalid;
        logic [31:0] mem_raddr;
        logic [6:0]  mem_rwidth;
        logic [31:0] mem_rdata;
        logic        mem_wvalid;
        logic [31:0] mem_waddr;
        logic [6:0]  mem_wwidth;
        logic [31:0] mem_wdata;
        logic        evt_valid;
        logic [31:0] evt_cause;
`ifdef COMMIT_TRACE_SEQCHK_EN
        logic [31:0] seq;
`endif
    } rec_t;

    rec_t             mem [DEPTH];
    rec_t             in_rec;
    rec_t             head_rec;
    rec_t             head_nxt;
    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    logic [PTR_W-1:0] head_adv;
    logic [LVL_W-1:0] level_nxt;
    logic             push;
    logic             pop;
    logic             drop;
`ifdef COMMIT_TRACE_SEQCHK_EN
    logic [31:0]      seq_cnt;
    logic [31:0]      last_next_pc;
    logic             seen;
`endif

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    // Pack the incoming commit fields into one storage record
    always_comb begin
        in_rec            = '0;
        in_rec.inst       = bus.in_inst;
        in_rec.pc         = bus.in_pc;
        in_rec.next_pc    = bus.in_next_pc;
        in_rec.mem_rvalid = bus.in_mem_rvalid;
        in_rec.mem_raddr  = bus.in_mem_raddr;
        in_rec.mem_rwidth = bus.in_mem_rwidth;
        in_rec.mem_rdata  = bus.in_mem_rdata;
        in_rec.mem_wvalid = bus.in_mem_wvalid;
        in_rec.mem_waddr  = bus.in_mem_waddr;
        in_rec.mem_wwidth = bus.in_mem_wwidth;
        in_rec.mem_wdata  = bus.in_mem_wdata;
        in_rec.evt_valid  = bus.in_evt_valid;
        in_rec.evt_cause  = bus.in_evt_cause;
`ifdef COMMIT_TRACE_SEQCHK_EN
        in_rec.seq        = seq_cnt;
`endif
    end

    // Decode push/pop/drop and pick the record the output register loads next;
    // a push into the slot that becomes head forwards the incoming record
    always_comb begin
        pop       = (level != '0) && bus.out_ready;
        push      = bus.in_valid && ((level != FULL_LVL) || pop);
        drop      = bus.in_valid && (level == FULL_LVL) && !pop;
        head_adv  = pop ? head + PTR_W'(1) : head;
        level_nxt = level;
        if (push && !pop) begin
            level_nxt = level + LVL_W'(1);
        end else if (pop && !push) begin
            level_nxt = level - LVL_W'(1);
        end
        if (level_nxt == '0) begin
            head_nxt = '0;
        end else if (push && (tail == head_adv)) begin
            head_nxt = in_rec;
        end else begin
            head_nxt = mem[head_adv];
        end
    end

    // Pointers, occupancy, drop bookkeeping and the registered head record
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            head     <= '0;
            tail     <= '0;
            level    <= '0;
            overflow <= 1'b0;
            drop_cnt <= '0;
            head_rec <= '0;
        end else begin
            head     <= head_adv;
            level    <= level_nxt;
            head_rec <= head_nxt;
            if (push) begin
                tail <= tail + PTR_W'(1);
            end
            if (drop) begin
                overflow <= 1'b1;
                drop_cnt <= sat_inc(drop_cnt);
            end
        end
    end

    // Record storage is not reset; empty slots are never presented
    always_ff @(posedge clock) begin
        if (push) begin
            mem[tail] <= in_rec;
        end
    end

`ifdef COMMIT_TRACE_SEQCHK_EN
    // Sequence numbering and PC continuity track every commit, dropped or not
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            seq_cnt      <= '0;
            last_next_pc <= '0;
            seen         <= 1'b0;
            pc_break     <= 1'b0;
        end else if (bus.in_valid) begin
            seq_cnt      <= seq_cnt + 32'd1;
            last_next_pc <= bus.in_next_pc;
            seen         <= 1'b1;
            if (push && seen && (bus.in_pc != last_next_pc)) begin
                pc_break <= 1'b1;
            end
        end
    end

    assign out_seq = head_rec.seq;
`endif

    assign bus.out_valid      = (level != '0);
    assign bus.out_inst       = head_rec.inst;
    assign bus.out_pc         = head_rec.pc;
    assign bus.out_next_pc    = head_rec.next_pc;
    assign bus.out_mem_rvalid = head_rec.mem_rvalid;
    assign bus.out_mem_raddr  = head_rec.mem_raddr;
    assign bus.out_mem_rwidth = head_rec.mem_rwidth;
    assign bus.out_mem_rdata  = head_rec.mem_rdata;
    assign bus.out_mem_wvalid = head_rec.mem_wvalid;
    assign bus.out_mem_waddr  = head_rec.mem_waddr;
    assign bus.out_mem_wwidth = head_rec.mem_wwidth;
    assign bus.out_mem_wdata  = head_rec.mem_wdata;
    assign bus.out_evt_valid  = head_rec.evt_valid;
    assign bus.out_evt_cause  = head_rec.evt_cause;
endmodule

// File: tb/tb_commit_trace_buffer.sv
// Testbench for commit_trace_buffer: scenario tasks drive commits and push the
// records expected to be stored onto a queue; a negedge monitor pops and
// compares every record the checker side accepts.
module tb_commit_trace_buffer;
    localparam int DEPTH = 4;
    localparam int CNT_W = 8;

    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] pc;
        logic [31:0] next_pc;
        logic        rvalid;
        logic [31:0] raddr;
        logic [6:0]  rwidth;
        logic [31:0] rdata;
        logic        wvalid;
        logic [31:0] waddr;
        logic [6:0]  wwidth;
        logic [31:0] wdata;
        logic        evt_valid;
        logic [31:0] evt_cause;
`ifdef COMMIT_TRACE_SEQCHK_EN
        logic [31:0] seq;
`endif
    } rec_t;

    logic             clock;
    logic             reset;
    logic [2:0]       level;
    logic             overflow;
    logic [CNT_W-1:0] drop_cnt;
`ifdef COMMIT_TRACE_SEQCHK_EN
    logic [31:0]      out_seq;
    logic             pc_break;
`endif

    int          errors;
    int          checks;
    rec_t        exp_q[$];
    logic [31:0] tb_seq;

    commit_trace_buffer_if bus_if ();

    commit_trace_buffer #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clock    (clock),
        .reset    (reset),
        .bus      (bus_if),
        .level    (level),
        .overflow (overflow),
        .drop_cnt (drop_cnt)
`ifdef COMMIT_TRACE_SEQCHK_EN
        ,
        .out_seq  (out_seq),
        .pc_break (pc_break)
`endif
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic rec_t make_rec(input logic [31:0] pc, input logic [31:0] inst,
                                      input logic [31:0] next_pc);
        rec_t r;
        r         = '0;
        r.pc      = pc;
        r.inst    = inst;
        r.next_pc = next_pc;
        return r;
    endfunction

    function automatic rec_t observed();
        rec_t r;
        r           = '0;
        r.inst      = bus_if.out_inst;
        r.pc        = bus_if.out_pc;
        r.next_pc   = bus_if.out_next_pc;
        r.rvalid    = bus_if.out_mem_rvalid;
        r.raddr     = bus_if.out_mem_raddr;
        r.rwidth    = bus_if.out_mem_rwidth;
        r.rdata     = bus_if.out_mem_rdata;
        r.wvalid    = bus_if.out_mem_wvalid;
        r.waddr     = bus_if.out_mem_waddr;
        r.wwidth    = bus_if.out_mem_wwidth;
        r.wdata     = bus_if.out_mem_wdata;
        r.evt_valid = bus_if.out_evt_valid;
        r.evt_cause = bus_if.out_evt_cause;
`ifdef COMMIT_TRACE_SEQCHK_EN
        r.seq       = out_seq;
`endif
        return r;
    endfunction

    // Scoreboard monitor: every accepted head record must match the oldest expected one
    always @(negedge clock) begin
        rec_t exp_r;
        rec_t obs_r;
        if (reset && bus_if.out_valid && bus_if.out_ready) begin
            checks++;
            obs_r = observed();
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL drain_unexpected: got pc=%h inst=%h, required no record", obs_r.pc, obs_r.inst);
            end else begin
                exp_r = exp_q.pop_front();
                if (obs_r !== exp_r) begin
                    errors++;
                    $display("FAIL drain_record: got pc=%h inst=%h rec=%h, required pc=%h inst=%h rec=%h",
                             obs_r.pc, obs_r.inst, obs_r, exp_r.pc, exp_r.inst, exp_r);
                end
            end
        end
    end

    // One clock of stimulus; predicts acceptance and queues expected records
    task automatic cycle(input logic v, input rec_t r, input logic rdy);
        int unsigned sz;
        bit          pop_now;
        bus_if.in_valid      = v;
        bus_if.in_inst       = r.inst;
        bus_if.in_pc         = r.pc;
        bus_if.in_next_pc    = r.next_pc;
        bus_if.in_mem_rvalid = r.rvalid;
        bus_if.in_mem_raddr  = r.raddr;
        bus_if.in_mem_rwidth = r.rwidth;
        bus_if.in_mem_rdata  = r.rdata;
        bus_if.in_mem_wvalid = r.wvalid;
        bus_if.in_mem_waddr  = r.waddr;
        bus_if.in_mem_wwidth = r.wwidth;
        bus_if.in_mem_wdata  = r.wdata;
        bus_if.in_evt_valid  = r.evt_valid;
        bus_if.in_evt_cause  = r.evt_cause;
        bus_if.out_ready     = rdy;
        sz      = exp_q.size();
        pop_now = rdy && (sz != 0);
        if (v) begin
`ifdef COMMIT_TRACE_SEQCHK_EN
            r.seq = tb_seq;
`endif
            tb_seq = tb_seq + 32'd1;
            if ((sz < DEPTH) || pop_now) exp_q.push_back(r);
        end
        @(posedge clock);
        #1;
    endtask

    task automatic apply_reset();
        bus_if.in_valid  = 1'b0;
        bus_if.out_ready = 1'b0;
        reset            = 1'b0;
        exp_q.delete();
        tb_seq = '0;
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b1;
    endtask

    task automatic test_reset();
        rec_t idle;
        idle = '0;
        cycle(1'b0, idle, 1'b0);
        cycle(1'b0, idle, 1'b0);
        checks++; if (bus_if.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b, required 0", bus_if.out_valid); end
        checks++; if (level !== 3'd0) begin errors++; $display("FAIL reset_level: got %0d, required 0", level); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow: got %b, required 0", overflow); end
        checks++; if (drop_cnt !== 8'd0) begin errors++; $display("FAIL reset_drop_cnt: got %0d, required 0", drop_cnt); end
        checks++; if (bus_if.out_pc !== 32'h0 || bus_if.out_inst !== 32'h0) begin errors++; $display("FAIL reset_out_data: got pc=%h inst=%h, required 0/0", bus_if.out_pc, bus_if.out_inst); end
        reset = 1'b1;
    endtask

    task automatic test_pass_through();
        rec_t idle;
        idle = '0;
        cycle(1'b1, make_rec(32'h0, 32'h00100093, 32'h4), 1'b1);
        checks++; if (bus_if.out_valid !== 1'b1) begin errors++; $display("FAIL pass_out_valid: got %b, required 1", bus_if.out_valid); end
        checks++; if (bus_if.out_pc !== 32'h0 || bus_if.out_inst !== 32'h00100093) begin errors++; $display("FAIL pass_head: got pc=%h inst=%h, required 00000000/00100093", bus_if.out_pc, bus_if.out_inst); end
        checks++; if (level !== 3'd1) begin errors++; $display("FAIL pass_level1: got %0d, required 1", level); end
        cycle(1'b0, idle, 1'b1);
        checks++; if (level !== 3'd0 || bus_if.out_valid !== 1'b0) begin errors++; $display("FAIL pass_level0: got level=%0d valid=%b, required 0/0", level, bus_if.out_valid); end
        checks++; if (bus_if.out_inst !== 32'h0) begin errors++; $display("FAIL pass_empty_zero: got inst=%h, required 0", bus_if.out_inst); end
    endtask

    task automatic test_backpressure();
        rec_t idle;
        idle = '0;
        for (int i = 0; i < 4; i++) cycle(1'b1, make_rec(32'(i * 4), 32'h00000013 + 32'(i), 32'(i * 4 + 4)), 1'b0);
        checks++; if (level !== 3'd4) begin errors++; $display("FAIL bp_level: got %0d, required 4", level); end
        checks++; if (bus_if.out_pc !== 32'h0) begin errors++; $display("FAIL bp_head_hold: got %h, required 0", bus_if.out_pc); end
        cycle(1'b0, idle, 1'b0);
        checks++; if (bus_if.out_pc !== 32'h0 || level !== 3'd4) begin errors++; $display("FAIL bp_stable: got pc=%h level=%0d, required 0/4", bus_if.out_pc, level); end
        for (int i = 0; i < 4; i++) cycle(1'b0, idle, 1'b1);
        checks++; if (level !== 3'd0 || overflow !== 1'b0) begin errors++; $display("FAIL bp_drained: got level=%0d ovf=%b, required 0/0", level, overflow); end
        checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL bp_all_seen: got %0d left, required 0", exp_q.size()); end
    endtask

    task automatic test_overflow();
        rec_t idle;
        idle = '0;
        for (int i = 0; i < 6; i++) cycle(1'b1, make_rec(32'h40 + 32'(i * 4), 32'h00200113 + 32'(i), 32'h44 + 32'(i * 4)), 1'b0);
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_flag: got %b, required 1", overflow); end
        checks++; if (drop_cnt !== 8'd2) begin errors++; $display("FAIL ovf_drop_cnt: got %0d, required 2", drop_cnt); end
        checks++; if (level !== 3'd4) begin errors++; $display("FAIL ovf_level: got %0d, required 4", level); end
        for (int i = 0; i < 5; i++) cycle(1'b0, idle, 1'b1);
        checks++; if (level !== 3'd0 || overflow !== 1'b1) begin errors++; $display("FAIL ovf_after_drain: got level=%0d ovf=%b, required 0/1", level, overflow); end
        checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL ovf_all_seen: got %0d left, required 0", exp_q.size()); end
    endtask

    task automatic test_full_push_pop();
        rec_t idle;
        idle = '0;
        apply_reset();
        for (int i = 0; i < 4; i++) cycle(1'b1, make_rec(32'h100 + 32'(i * 4), 32'h00300193 + 32'(i), 32'h104 + 32'(i * 4)), 1'b0);
        cycle(1'b1, make_rec(32'h200, 32'h00400213, 32'h204), 1'b1);
        checks++; if (level !== 3'd4) begin errors++; $display("FAIL full_pp_level: got %0d, required 4", level); end
        checks++; if (overflow !== 1'b0 || drop_cnt !== 8'd0) begin errors++; $display("FAIL full_pp_no_drop: got ovf=%b cnt=%0d, required 0/0", overflow, drop_cnt); end
        checks++; if (bus_if.out_pc !== 32'h104) begin errors++; $display("FAIL full_pp_head: got %h, required 00000104", bus_if.out_pc); end
        for (int i = 0; i < 4; i++) cycle(1'b0, idle, 1'b1);
        checks++; if (level !== 3'd0 || exp_q.size() != 0) begin errors++; $display("FAIL full_pp_drained: got level=%0d left=%0d, required 0/0", level, exp_q.size()); end
    endtask

    task automatic test_mem_evt_reset();
        rec_t idle;
        rec_t st;
        rec_t tr;
        rec_t ld;
        idle = '0;
        apply_reset();
        st = make_rec(32'h10, 32'h00a12023, 32'h14);
        st.wvalid = 1'b1; st.waddr = 32'h100; st.wwidth = 7'd32; st.wdata = 32'hDEADBEEF;
        tr = make_rec(32'h14, 32'h00000073, 32'h80);
        tr.evt_valid = 1'b1; tr.evt_cause = 32'd2;
        ld = make_rec(32'h80, 32'h00011083, 32'h84);
        ld.rvalid = 1'b1; ld.raddr = 32'h202; ld.rwidth = 7'd16; ld.rdata = 32'h0000BEEF;
        cycle(1'b1, st, 1'b0);
        cycle(1'b1, tr, 1'b0);
        cycle(1'b1, ld, 1'b0);
        cycle(1'b1, make_rec(32'h84, 32'h00000013, 32'h88), 1'b0);
        cycle(1'b1, make_rec(32'h88, 32'h00000013, 32'h8C), 1'b0);
        checks++; if (drop_cnt !== 8'd1 || level !== 3'd4) begin errors++; $display("FAIL mem_fill: got cnt=%0d level=%0d, required 1/4", drop_cnt, level); end
        checks++; if (bus_if.out_mem_wdata !== 32'hDEADBEEF || bus_if.out_mem_waddr !== 32'h100 || bus_if.out_mem_wwidth !== 7'd32) begin errors++; $display("FAIL mem_store_head: got %h/%h/%0d, required deadbeef/00000100/32", bus_if.out_mem_wdata, bus_if.out_mem_waddr, bus_if.out_mem_wwidth); end
        cycle(1'b0, idle, 1'b1);
        checks++; if (bus_if.out_evt_valid !== 1'b1 || bus_if.out_evt_cause !== 32'd2) begin errors++; $display("FAIL evt_head: got %b/%0d, required 1/2", bus_if.out_evt_valid, bus_if.out_evt_cause); end
        cycle(1'b0, idle, 1'b1);
        checks++; if (level !== 3'd2) begin errors++; $display("FAIL mem_held: got %0d, required 2", level); end
        bus_if.out_ready = 1'b0;
        reset = 1'b0;
        exp_q.delete();
        tb_seq = '0;
        #2;
        checks++; if (bus_if.out_valid !== 1'b0 || level !== 3'd0) begin errors++; $display("FAIL async_reset_ctrl: got valid=%b level=%0d, required 0/0", bus_if.out_valid, level); end
        checks++; if (drop_cnt !== 8'd0 || overflow !== 1'b0) begin errors++; $display("FAIL async_reset_drop: got cnt=%0d ovf=%b, required 0/0", drop_cnt, overflow); end
        checks++; if (bus_if.out_pc !== 32'h0 || bus_if.out_mem_rdata !== 32'h0) begin errors++; $display("FAIL async_reset_data: got pc=%h rdata=%h, required 0/0", bus_if.out_pc, bus_if.out_mem_rdata); end
        @(posedge clock);
        #1;
        reset = 1'b1;
    endtask

`ifdef COMMIT_TRACE_SEQCHK_EN
    task automatic test_seqchk();
        rec_t idle;
        idle = '0;
        apply_reset();
        cycle(1'b1, make_rec(32'h0, 32'h00100093, 32'h4), 1'b0);
        checks++; if (pc_break !== 1'b0) begin errors++; $display("FAIL seq_first_exempt: got %b, required 0", pc_break); end
        cycle(1'b1, make_rec(32'h8, 32'h00200113, 32'hC), 1'b0);
        checks++; if (pc_break !== 1'b1) begin errors++; $display("FAIL seq_pc_break: got %b, required 1", pc_break); end
        checks++; if (out_seq !== 32'd0) begin errors++; $display("FAIL seq_head0: got %0d, required 0", out_seq); end
        cycle(1'b0, idle, 1'b1);
        checks++; if (out_seq !== 32'd1) begin errors++; $display("FAIL seq_head1: got %0d, required 1", out_seq); end
        cycle(1'b0, idle, 1'b1);
        checks++; if (exp_q.size() != 0 || pc_break !== 1'b1) begin errors++; $display("FAIL seq_drained: got left=%0d brk=%b, required 0/1", exp_q.size(), pc_break); end
    endtask
`endif

    initial begin
        errors           = 0;
        checks           = 0;
        tb_seq           = '0;
        reset            = 1'b0;
        bus_if.in_valid  = 1'b0;
        bus_if.out_ready = 1'b0;
        test_reset();
        test_pass_through();
        test_backpressure();
        test_overflow();
        test_full_push_pop();
        test_mem_evt_reset();
`ifdef COMMIT_TRACE_SEQCHK_EN
        test_seqchk();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/commit_trace_buffer.md
Name: commit_trace_buffer

Overview:
- Sits between the core's commit-trace outputs (nerv_extended_wrapper) and the checker in the formal/sim top.
- Captures one commit record per cycle into a FIFO with no backpressure to the core, since the core cannot stall.
- Replays records to the checker through a valid/ready handshake.
- Flags overflow and keeps a saturating count of dropped records.

Parameters:
- DEPTH, 4, number of FIFO entries; must be a power of 2 and ≥2.
- CNT_W, 8, width of the drop counter.

Ports:
- clock  in  1  sole clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- in_valid  in  1  commit strobe from the core (instCommit_valid).
- in_inst  in  32  committed instruction.
- in_pc  in  32  PC of the committed instruction.
- in_next_pc  in  32  PC after the commit (result_pc).
- in_mem_rvalid  in  1  load performed.
- in_mem_raddr  in  32  load address.
- in_mem_rwidth  in  7  load width in bits (8/16/32).
- in_mem_rdata  in  32  load data.
- in_mem_wvalid  in  1  store performed.
- in_mem_waddr  in  32  store address.
- in_mem_wwidth  in  7  store width in bits.
- in_mem_wdata  in  32  store data.
- in_evt_valid  in  1  exception event.
- in_evt_cause  in  32  mcause value.
- out_valid  out  1  head record available.
- out_ready  in  1  checker accepts the head record.
- out_* (one per in_* data field, same widths)  out  —  head record fields.
- level  out  clog2(DEPTH)+1  current occupancy.
- overflow  out  1  sticky; a record was dropped.
- drop_cnt  out  CNT_W  dropped records, saturating.

Behaviour:
- Reset (asynchronous, reset=0):
  - Pointers and level go to 0.
  - out_valid=0, overflow=0, drop_cnt=0.
  - All out_* data fields go to 0.
  - A reset asserted mid-operation discards all stored records immediately.
- Push:
  - Occurs on a rising edge with in_valid=1, unless the FIFO is full and no pop happens in the same cycle.
  - The full record (all in_* fields) is written at the tail and the tail pointer increments modulo DEPTH.
  - Data fields are sampled only when in_valid=1.
- Pop:
  - Occurs when out_valid && out_ready; the head pointer increments modulo DEPTH.
- Output timing:
  - out_valid = (level != 0).
  - out_* are driven from the head storage entry, registered and with no combinational path from in_*.
  - Latency from push edge to out_valid is 1 cycle.
  - out_* remain stable while out_valid && !out_ready.
- Level update:
  - Push only: +1.
  - Pop only: −1.
  - Both: unchanged.
- Full and simultaneous pop: when level==DEPTH, a push with a pop in the same cycle is accepted and level stays at DEPTH.
- Full and no pop: when level==DEPTH, in_valid=1 and no pop, the record is dropped:
  - overflow is set and stays set until reset.
  - drop_cnt increments, saturating at 2^CNT_W−1.
  - Stored contents are unchanged.
- Empty: when level==0, out_ready is ignored and no pointer moves. There is no bypass: a record pushed while empty appears on the next cycle.
- Pointer wrap-around is natural modulo DEPTH. Full and empty are distinguished by level, not by pointer equality.
- No X propagation: storage is not reset, but out_* read 0 when level==0.

Optional Feature:
- Macro: COMMIT_TRACE_SEQCHK_EN
- When defined, the following are added:
  - Output out_seq [31:0]: a per-record sequence number, assigned at push from a counter that increments on every in_valid, including dropped records. The checker can therefore see gaps.
  - Output pc_break [1]: a sticky flag, set when an accepted in_valid has in_pc different from the in_next_pc of the previous in_valid.
    - The first commit after reset is exempt.
    - The comparison uses the last seen in_next_pc, whether that record was stored or dropped.
  - Both outputs reset to 0.
- When not defined, these ports and their logic are absent and the behaviour is otherwise identical.

Test Plan:
- Basic pass-through:
  - Stimulus: reset low for 2 cycles, release; out_ready=1; one commit (in_pc=0x0, in_inst=0x00100093, in_next_pc=0x4).
  - Required response: the next cycle shows out_valid=1 with out_pc=0x0, out_inst=0x00100093; level returns to 0 one cycle later.
- Backpressure and ordering:
  - Stimulus: out_ready=0; 4 commits with in_pc=0x0, 0x4, 0x8, 0xC.
  - Required response: level=4 and out_pc holds 0x0. Then out_ready=1 drains 0x0, 0x4, 0x8, 0xC in 4 consecutive cycles, with no overflow.
- Overflow:
  - Stimulus: DEPTH=4, out_ready=0; 6 commits.
  - Required response: overflow=1, drop_cnt=2, and the drained records are the first 4 only.
- Full with simultaneous push and pop:
  - Stimulus: FIFO full; in_valid=1 and out_ready=1 in the same cycle.
  - Required response: level stays 4, overflow stays 0, and the new record appears last in the drain order.
- Memory and event fields, then reset mid-stream:
  - Stimulus: a store commit (waddr=0x100, wwidth=32, wdata=0xDEADBEEF) followed by a trap commit (evt_valid=1, cause=2), both buffered; then reset asserted with 2 records still held.
  - Required response: the buffered fields emerge bit-exact. The reset asynchronously forces out_valid=0, level=0 and drop_cnt=0 before the next edge.
- With COMMIT_TRACE_SEQCHK_EN:
  - Stimulus: commits with in_pc=0x0 (next_pc 0x4) then in_pc=0x8.
  - Required response: pc_break=1; out_seq values are 0 and 1.
